// File: rtl/mem_arbiter_if.sv
// Port bundle for mem_arbiter: fetch and data requester handshakes plus the shared memory bus.
// The arbiter takes the slave view; the surrounding CPU/memory environment takes the master view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_rw;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;

  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_rw, dm_addr, dm_wdata, bus_ack, bus_rdata,
    output if_done, if_rdata, dm_done, dm_rdata, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_rw, dm_addr, dm_wdata, bus_ack, bus_rdata,
    input  if_done, if_rdata, dm_done, dm_rdata, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-ported memory bus: data beats fetch, except that a
// bounded run of data grants while fetch waits forces the next grant to fetch.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave arb
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic          owner;
  logic [CW-1:0] starve_cnt;

  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          if_done;
  logic          dm_done;
  logic [DW-1:0] if_rdata;
  logic [DW-1:0] dm_rdata;

  logic any_req;
  logic starved;
  logic fetch_win;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    any_req   = arb.if_req | arb.dm_req;
    starved   = (starve_cnt == CNT_MAX);
    fetch_win = arb.if_req & (~arb.dm_req | starved);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        // Arbitration: the winner's fields are frozen onto the bus for the whole transaction
        IDLE: begin
          if (any_req) begin
            state   <= BUSY;
            bus_req <= 1'b1;
            owner   <= ~fetch_win;
            if (fetch_win) begin
              bus_we   <= 1'b0;
              bus_addr <= arb.if_addr;
            end else begin
              bus_we    <= arb.dm_rw;
              bus_addr  <= arb.dm_addr;
              bus_wdata <= arb.dm_wdata;
            end
            starve_cnt <= (~fetch_win & arb.if_req) ? sat_inc(starve_cnt) : '0;
          end
        end
        // Memory access: wait for the ack and route read data to the owner only
        BUSY: begin
          if (arb.bus_ack) begin
            bus_req <= 1'b0;
            state   <= DONE;
            if (owner) begin
              dm_done <= 1'b1;
              if (!bus_we) dm_rdata <= arb.bus_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= arb.bus_rdata;
            end
          end
        end
        // Done pulse cycle: deliberately no arbitration so a still-held request is not re-granted
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign arb.bus_req   = bus_req;
  assign arb.bus_we    = bus_we;
  assign arb.bus_addr  = bus_addr;
  assign arb.bus_wdata = bus_wdata;
  assign arb.if_done   = if_done;
  assign arb.if_rdata  = if_rdata;
  assign arb.dm_done   = dm_done;
  assign arb.dm_rdata  = dm_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a timestamp-based transaction model predicts every output each cycle;
// directed scenarios pin the model with literal values, then randomized traffic runs against it.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clock(clock),
    .reset(reset),
    .arb  (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;

  // drive values for the current cycle
  bit            drv_reset, drv_if_req, drv_dm_req, drv_dm_rw, drv_ack_force;
  logic [AW-1:0] drv_if_addr, drv_dm_addr;
  logic [DW-1:0] drv_dm_wdata;

  // behavioural model: one transaction described by grant time and latency
  bit            any_txn;
  int            t_g, lat, free_at, cnt;
  bit            own_d, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_ackdata, m_if_rdata, m_dm_rdata;
  string         glog;

  // scenario knobs
  int            force_lat;
  bit            fd_en, spur_en, auto_en, cont;
  logic [DW-1:0] force_data;
  bit            if_pend, dm_pend;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, n, act, exp);
    end
  endtask

  task automatic check();
    bit e_req;
    e_req = any_txn && (n >= t_g + 1) && (n <= t_g + lat);
    chk("bus_req", bus_if.bus_req, e_req);
    chk("bus_we", bus_if.bus_we, m_we);
    chk("bus_addr", bus_if.bus_addr, m_addr);
    if (e_req && m_we) chk("bus_wdata", bus_if.bus_wdata, m_wdata);
    chk("if_done", bus_if.if_done, any_txn && !own_d && (n == t_g + lat + 1));
    chk("dm_done", bus_if.dm_done, any_txn && own_d && (n == t_g + lat + 1));
    chk("if_rdata", bus_if.if_rdata, m_if_rdata);
    chk("dm_rdata", bus_if.dm_rdata, m_dm_rdata);
    if (any_txn && (n == t_g + 1)) chk("starve_cnt", dut.starve_cnt, cnt);
  endtask

  task automatic auto_drive();
    if (any_txn && (n == t_g + lat + 2)) begin
      if (own_d) dm_pend = 1'b0;
      else       if_pend = 1'b0;
    end
    if (!if_pend && (cont || $urandom_range(0, 3) == 0)) begin
      if_pend     = 1'b1;
      drv_if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dm_pend && (cont || $urandom_range(0, 3) == 0)) begin
      dm_pend      = 1'b1;
      drv_dm_rw    = 1'($urandom_range(0, 1));
      drv_dm_addr  = $urandom & 32'hFFFF_FFFC;
      drv_dm_wdata = $urandom;
    end
    drv_if_req = if_pend;
    drv_dm_req = dm_pend;
  endtask

  task automatic apply();
    bit ack_now, in_win;
    ack_now = any_txn && (n == t_g + lat);
    in_win  = any_txn && (n >= t_g + 1) && (n <= t_g + lat);
    reset            = drv_reset;
    bus_if.if_req    = drv_if_req;
    bus_if.if_addr   = drv_if_addr;
    bus_if.dm_req    = drv_dm_req;
    bus_if.dm_rw     = drv_dm_rw;
    bus_if.dm_addr   = drv_dm_addr;
    bus_if.dm_wdata  = drv_dm_wdata;
    bus_if.bus_ack   = ack_now || drv_ack_force || (spur_en && !in_win && $urandom_range(0, 5) == 0);
    bus_if.bus_rdata = ack_now ? m_ackdata : $urandom;
  endtask

  task automatic model_advance();
    bit fw;
    if (drv_reset) begin
      any_txn    = 1'b0;
      m_we       = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      m_if_rdata = '0;
      m_dm_rdata = '0;
      cnt        = 0;
      free_at    = n + 1;
      return;
    end
    if (any_txn && (n == t_g + lat)) begin
      if (!own_d)     m_if_rdata = m_ackdata;
      else if (!m_we) m_dm_rdata = m_ackdata;
    end
    if ((n >= free_at) && (drv_if_req || drv_dm_req)) begin
      fw        = drv_if_req && (!drv_dm_req || cnt == SMAX);
      cnt       = (!fw && drv_if_req) ? ((cnt < SMAX) ? cnt + 1 : SMAX) : 0;
      any_txn   = 1'b1;
      t_g       = n;
      lat       = (force_lat > 0) ? force_lat : int'($urandom_range(1, 5));
      own_d     = !fw;
      m_addr    = fw ? drv_if_addr : drv_dm_addr;
      m_we      = fw ? 1'b0 : drv_dm_rw;
      if (!fw) m_wdata = drv_dm_wdata;
      m_ackdata = fd_en ? force_data : $urandom;
      free_at   = n + lat + 2;
      if (fw) glog = {glog, "I"};
      else    glog = {glog, "D"};
    end
  endtask

  // one clock: drive cycle n, advance model, then check cycle n+1 on the falling edge
  task automatic step();
    if (auto_en) auto_drive();
    apply();
    model_advance();
    @(posedge clock);
    n++;
    @(negedge clock);
    check();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    drv_reset = 1'b1; drv_if_req = 1'b0; drv_dm_req = 1'b0; drv_dm_rw = 1'b0; drv_ack_force = 1'b0;
    drv_if_addr = '0; drv_dm_addr = '0; drv_dm_wdata = '0;
    any_txn = 1'b0; t_g = 0; lat = 1; free_at = 0; cnt = 0; own_d = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_ackdata = '0; m_if_rdata = '0; m_dm_rdata = '0; glog = "";
    force_lat = 1; fd_en = 1'b0; spur_en = 1'b0; auto_en = 1'b0; cont = 1'b0; force_data = '0;
    if_pend = 1'b0; dm_pend = 1'b0;
    apply();
    @(negedge clock);
    step();
    step();
    chk("rst_bus_req", bus_if.bus_req, 0);
    chk("rst_bus_addr", bus_if.bus_addr, 0);
    chk("rst_if_rdata", bus_if.if_rdata, 0);
    chk("rst_dm_done", bus_if.dm_done, 0);
    drv_reset = 1'b0;

    // fetch only, L=1
    force_lat = 1; fd_en = 1'b1; force_data = 32'hDEADBEEF;
    drv_if_req = 1'b1; drv_if_addr = 32'h100;
    step();
    chk("fo_bus_req", bus_if.bus_req, 1);
    chk("fo_bus_we", bus_if.bus_we, 0);
    chk("fo_bus_addr", bus_if.bus_addr, 32'h100);
    chk("fo_starve", dut.starve_cnt, 0);
    step();
    chk("fo_if_done", bus_if.if_done, 1);
    chk("fo_if_rdata", bus_if.if_rdata, 32'hDEADBEEF);
    drv_if_req = 1'b0;
    step();
    chk("fo_if_done_low", bus_if.if_done, 0);

    // simultaneous data write + fetch, L=1
    fd_en = 1'b0;
    drv_dm_req = 1'b1; drv_dm_rw = 1'b1; drv_dm_addr = 32'h200; drv_dm_wdata = 32'h1234;
    drv_if_req = 1'b1; drv_if_addr = 32'h40;
    step();
    chk("sim_bus_we", bus_if.bus_we, 1);
    chk("sim_bus_addr", bus_if.bus_addr, 32'h200);
    chk("sim_bus_wdata", bus_if.bus_wdata, 32'h1234);
    step();
    chk("sim_dm_done", bus_if.dm_done, 1);
    chk("sim_dm_rdata", bus_if.dm_rdata, 0);
    drv_dm_req = 1'b0;
    step();
    chk("sim_gap_req", bus_if.bus_req, 0);
    step();
    chk("sim_f_req", bus_if.bus_req, 1);
    chk("sim_f_addr", bus_if.bus_addr, 32'h40);
    step();
    chk("sim_if_done", bus_if.if_done, 1);
    drv_if_req = 1'b0;
    step();

    // wait states, L=5, request held through its done cycle
    force_lat = 5;
    drv_dm_req = 1'b1; drv_dm_rw = 1'b0; drv_dm_addr = 32'h500;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ws_bus_req", bus_if.bus_req, 1);
      chk("ws_bus_addr", bus_if.bus_addr, 32'h500);
      chk("ws_bus_we", bus_if.bus_we, 0);
      chk("ws_dm_done", bus_if.dm_done, 0);
    end
    step();
    chk("ws_done", bus_if.dm_done, 1);
    step();
    chk("ws_no_regrant", bus_if.bus_req, 0);
    chk("ws_done_once", bus_if.dm_done, 0);
    drv_dm_req = 1'b0;
    step();

    // reset in the second BUSY cycle, stale ack two cycles later
    drv_if_req = 1'b1; drv_if_addr = 32'h600;
    step();
    step();
    drv_reset = 1'b1; drv_if_req = 1'b0;
    step();
    chk("rm_bus_req", bus_if.bus_req, 0);
    chk("rm_bus_addr", bus_if.bus_addr, 0);
    chk("rm_dm_rdata", bus_if.dm_rdata, 0);
    drv_reset = 1'b0;
    step();
    drv_ack_force = 1'b1;
    step();
    drv_ack_force = 1'b0;
    chk("rm_ack_req", bus_if.bus_req, 0);
    chk("rm_if_done", bus_if.if_done, 0);
    chk("rm_if_rdata", bus_if.if_rdata, 0);
    step();
    chk("rm_dm_done", bus_if.dm_done, 0);

    // data read then fetch
    force_lat = 2; fd_en = 1'b1; force_data = 32'hCAFEF00D;
    drv_dm_req = 1'b1; drv_dm_rw = 1'b0; drv_dm_addr = 32'h300;
    step(); step(); step();
    chk("rf_dm_done", bus_if.dm_done, 1);
    chk("rf_dm_rdata", bus_if.dm_rdata, 32'hCAFEF00D);
    drv_dm_req = 1'b0;
    force_lat = 1; force_data = 32'h13;
    drv_if_req = 1'b1; drv_if_addr = 32'h0;
    step(); step(); step();
    chk("rf_if_done", bus_if.if_done, 1);
    chk("rf_if_rdata", bus_if.if_rdata, 32'h13);
    chk("rf_dm_keep", bus_if.dm_rdata, 32'hCAFEF00D);
    drv_if_req = 1'b0;
    step();

    // starvation: both requesters continuously busy
    force_lat = 0; fd_en = 1'b0; auto_en = 1'b1; cont = 1'b1;
    if_pend = 1'b0; dm_pend = 1'b0; glog = "";
    guard = 0;
    while (glog.len() < 10 && guard < 400) begin
      step();
      guard++;
    end
    n_cmp++;
    if (glog != "DDDDIDDDDI") begin
      n_bad++;
      $display("FAIL grant_order: got %s, expected DDDDIDDDDI", glog);
    end

    // randomized traffic with spurious acks outside transactions
    cont = 1'b0; spur_en = 1'b1;
    for (int i = 0; i < 2000; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
